seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential shift-add multiplier. Multiplies two WIDTH-bit operands over 2*WIDTH cycles through one internal (WIDTH+1)-bit add/subtract path.
- Generalises the fixed 8-bit datapath to any WIDTH and adds signed/unsigned modes, a start/busy/done handshake and a registered product.
- Sits between operand registers and the result/display logic. Upstream logic issues one multiply at a time.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- SIGNED, 1, 1 = two's-complement operands (Booth-free sign correction); 0 = unsigned operands.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Multiplicand  input  WIDTH  operand S; captured on accepted Start.
- Multiplier  input  WIDTH  operand B; captured on accepted Start.
- Busy  output  1  high from the cycle after an accepted Start through the DONE cycle.
- Done  output  1  single-cycle pulse; Product is valid from this cycle.
- Product  output  2*WIDTH  registered result; holds until the next completion.

Behaviour:

Reset:
- Reset_n low, asynchronously: state=IDLE, Busy=0, Done=0, Product=0, internal X/A/B/S/count=0.
- Reset_n low mid-operation aborts the operation. Product is cleared to 0, not left partial.

Internal registers:
- S (WIDTH): multiplicand.
- A (WIDTH): upper accumulator.
- B (WIDTH): multiplier, shifted out.
- X (1): sign/carry extension.
- count: 0..WIDTH-1.

States:
- IDLE:
  - Start=1: S<=Multiplicand, B<=Multiplier, A<=0, X<=0, count<=0, go to ADD.
  - Otherwise stay.
- ADD:
  - If B[0]=1: {X,A} <= ext(A) + ext(S). On the final iteration (count=WIDTH-1) with SIGNED=1, use ext(A) - ext(S) instead (add ~ext(S) with carry-in 1).
  - If B[0]=0: {X,A} unchanged.
  - ext() is sign-extension to WIDTH+1 when SIGNED=1, zero-extension when SIGNED=0.
  - Carry out of the (WIDTH+1)-bit sum is discarded.
  - Next state: SHIFT.
- SHIFT:
  - {X,A,B} shifted right one bit.
  - New X = X when SIGNED=1 (arithmetic shift); 0 when SIGNED=0.
  - If count=WIDTH-1: go to DONE. Otherwise count<=count+1, go to ADD.
- DONE:
  - Product<={A,B}, Done=1 for exactly this cycle, Busy=1.
  - Next state: IDLE unconditionally.

Timing:
- Start accepted at edge 0. Busy high from cycle 1. Done high in cycle 2*WIDTH+1. Busy low again in cycle 2*WIDTH+2.
- Back-to-back operation: Start held high in the first IDLE cycle after DONE is accepted, so issue period = 2*WIDTH+2 cycles.

Handshake and operand rules:
- Start while Busy=1 is ignored. No queueing, no effect on the operation in flight.
- Multiplicand/Multiplier changes after acceptance have no effect.
- Product changes only on the DONE cycle or on reset.

Arithmetic:
- The result equals the exact mathematical product for all operand pairs, including most-negative × most-negative in signed mode (result fits in 2*WIDTH bits).
- The X bit guarantees no overflow in the (WIDTH+1)-bit accumulator.

Boundary cases:
- Operand zero still takes the full 2*WIDTH+2 cycles (no early termination).
- Done and Start in the same cycle: Start ignored, because the state is DONE, not IDLE.

Test Plan:
- WIDTH=8, SIGNED=1: Start with 7 × -3 (0x07, 0xFD) -> Done pulse exactly 17 cycles after the Start edge; Product=0xFFEB; Busy high cycles 1-17, low at 18.
- WIDTH=8, SIGNED=1: -128 × -128 -> 0x4000; -128 × 127 -> 0xC080; 0 × -1 -> 0x0000.
- WIDTH=8, SIGNED=0: 255 × 255 -> 0xFE01; 200 × 3 -> 0x0258.
- WIDTH=8, SIGNED=1: Start 5 × 6, pulse Start again with 9 × 9 at cycle 4 -> second Start ignored; Product=0x001E; single Done pulse.
- WIDTH=8, SIGNED=1: Start 100 × 100, then assert Reset_n=0 asynchronously mid-cycle 6 -> Busy, Done and Product all 0 immediately. After release, a new Start with 3 × 4 -> Product=0x000C.
- WIDTH=16, SIGNED=1 and WIDTH=4, SIGNED=0: 1000 random operand pairs (WIDTH=4 exhaustive) against a reference model -> all products match; Done exactly 2*WIDTH+1 cycles after each accepted Start.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one (WIDTH+1)-bit add/subtract per bit of the multiplier,
// with signed (final-step subtract) or unsigned operands and a start/busy/done handshake.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             x;
    logic [CW-1:0]    count;

    logic             last;
    logic             sub;
    logic             shift_in;
    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_s;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;

    always_comb begin
        last     = (count == LAST);
        ext_a    = SIGNED ? {a[WIDTH-1], a} : {1'b0, a};
        ext_s    = SIGNED ? {s[WIDTH-1], s} : {1'b0, s};
        // In signed mode the multiplier's MSB carries negative weight, so its step subtracts.
        sub      = SIGNED && last;
        addend   = sub ? ~ext_s : ext_s;
        sum      = ext_a + addend + {{WIDTH{1'b0}}, sub};
        shift_in = SIGNED ? x : 1'b0;
        shifted  = {shift_in, x, a, b[WIDTH-1:1]};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            s       <= '0;
            a       <= '0;
            b       <= '0;
            x       <= 1'b0;
            count   <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        s     <= Multiplicand;
                        b     <= Multiplier;
                        a     <= '0;
                        x     <= 1'b0;
                        count <= '0;
                        Busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (b[0]) begin
                        {x, a} <= sum;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    {x, a, b} <= shifted;
                    if (last) begin
                        // Product is loaded with the post-shift value so it is valid in the DONE cycle.
                        Product <= shifted[2*WIDTH-1:0];
                        Done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: four configurations (8 signed, 8 unsigned, 16 signed,
// 4 unsigned) checked against plain integer multiplication.
module tb_seq_shift_add_multiplier;

    localparam int unsigned WID [4] = '{8, 8, 16, 4};
    localparam bit          SGN [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [4];
    logic [15:0] mc    [4];
    logic [15:0] mp    [4];
    logic        busy  [4];
    logic        done  [4];
    logic [31:0] prod  [4];

    logic [15:0] p8s;
    logic [15:0] p8u;
    logic [31:0] p16s;
    logic [7:0]  p4u;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
        .Clk(clk), .Reset_n(rst_n), .Start(start[0]),
        .Multiplicand(mc[0][7:0]), .Multiplier(mp[0][7:0]),
        .Busy(busy[0]), .Done(done[0]), .Product(p8s)
    );
    seq_shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
        .Clk(clk), .Reset_n(rst_n), .Start(start[1]),
        .Multiplicand(mc[1][7:0]), .Multiplier(mp[1][7:0]),
        .Busy(busy[1]), .Done(done[1]), .Product(p8u)
    );
    seq_shift_add_multiplier #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (
        .Clk(clk), .Reset_n(rst_n), .Start(start[2]),
        .Multiplicand(mc[2]), .Multiplier(mp[2]),
        .Busy(busy[2]), .Done(done[2]), .Product(p16s)
    );
    seq_shift_add_multiplier #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (
        .Clk(clk), .Reset_n(rst_n), .Start(start[3]),
        .Multiplicand(mc[3][3:0]), .Multiplier(mp[3][3:0]),
        .Busy(busy[3]), .Done(done[3]), .Product(p4u)
    );

    assign prod[0] = {16'h0000, p8s};
    assign prod[1] = {16'h0000, p8u};
    assign prod[2] = p16s;
    assign prod[3] = {24'h000000, p4u};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers of the configured width and multiply.
    function automatic logic [31:0] ref_mul(input int inst, input logic [15:0] opa, input logic [15:0] opb);
        longint m;
        longint va;
        longint vb;
        longint p;
        m  = longint'(1) << WID[inst];
        va = longint'({48'h0, opa}) & (m - 1);
        vb = longint'({48'h0, opb}) & (m - 1);
        if (SGN[inst]) begin
            if (va >= m / 2) va = va - m;
            if (vb >= m / 2) vb = vb - m;
        end
        p = (va * vb) & (m * m - 1);
        return 32'(p);
    endfunction

    function automatic logic [15:0] pick(input int unsigned w);
        int unsigned v;
        case ($urandom_range(0, 7))
            0:       v = 32'd1 << (w - 1);
            1:       v = (32'd1 << (w - 1)) - 1;
            2:       v = (32'd1 << w) - 1;
            3:       v = 0;
            default: v = $urandom & ((32'd1 << w) - 1);
        endcase
        return 16'(v);
    endfunction

    // Called at a negedge with the instance idle; returns at the negedge of cycle 2W+2.
    task automatic do_op(input int inst, input logic [15:0] opa, input logic [15:0] opb,
                         input logic [31:0] exp, input string tag);
        int lat;
        int busy_low;
        mc[inst]    = opa;
        mp[inst]    = opb;
        start[inst] = 1'b1;
        @(posedge clk);
        #1;
        start[inst] = 1'b0;
        mc[inst]    = 16'($urandom);
        mp[inst]    = 16'($urandom);
        lat      = 0;
        busy_low = 0;
        for (int cyc = 1; cyc <= 80 && lat == 0; cyc++) begin
            @(negedge clk);
            if (busy[inst] !== 1'b1) busy_low++;
            if (done[inst] === 1'b1) lat = cyc;
        end
        check({tag, "_latency"}, 32'(lat), 2 * WID[inst] + 1);
        check({tag, "_product"}, prod[inst], exp);
        check({tag, "_busy_window"}, 32'(busy_low), 32'd0);
        @(negedge clk);
        check({tag, "_end_busy_done"}, 32'({busy[inst], done[inst]}), 32'd0);
        check({tag, "_hold"}, prod[inst], exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int ndone;
        int nbusy;
        logic [15:0] ra;
        logic [15:0] rb;

        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            mc[i]    = '0;
            mp[i]    = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_busy_done_%0d", i), 32'({busy[i], done[i]}), 32'd0);
            check($sformatf("reset_product_%0d", i), prod[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 16'h0007, 16'h00FD, 32'h0000_FFEB, "s8_7x-3");
        do_op(0, 16'h0080, 16'h0080, 32'h0000_4000, "s8_min_x_min");
        do_op(0, 16'h0080, 16'h007F, 32'h0000_C080, "s8_min_x_max");
        do_op(0, 16'h0000, 16'h00FF, 32'h0000_0000, "s8_0x-1");
        do_op(1, 16'h00FF, 16'h00FF, 32'h0000_FE01, "u8_255x255");
        do_op(1, 16'h00C8, 16'h0003, 32'h0000_0258, "u8_200x3");

        // Start while busy (cycle 4) and Start coinciding with Done (cycle 17) must both be ignored.
        mc[0] = 16'd5;
        mp[0] = 16'd6;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        first_done = 0;
        ndone = 0;
        nbusy = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done[0] === 1'b1) begin
                ndone++;
                if (first_done == 0) first_done = cyc;
            end
            if (busy[0] === 1'b1) nbusy++;
            if (cyc == 4 || cyc == 17) begin
                start[0] = 1'b1;
                mc[0]    = 16'd9;
                mp[0]    = 16'd9;
            end else begin
                start[0] = 1'b0;
            end
        end
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_done_cycle", 32'(first_done), 32'd17);
        check("ignore_busy_cycles", 32'(nbusy), 32'd17);
        check("ignore_product", prod[0], 32'h0000_001E);

        // Asynchronous reset in the middle of cycle 6 aborts and clears everything at once.
        mc[0] = 16'd100;
        mp[0] = 16'd100;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy_done", 32'({busy[0], done[0]}), 32'd0);
        check("abort_product", prod[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 16'd3, 16'd4, 32'h0000_000C, "s8_after_abort");

        for (int n = 0; n < 100; n++) begin
            ra = pick(8);
            rb = pick(8);
            do_op(0, ra, rb, ref_mul(0, ra, rb), "rand_s8");
            ra = pick(8);
            rb = pick(8);
            do_op(1, ra, rb, ref_mul(1, ra, rb), "rand_u8");
        end
        for (int n = 0; n < 1000; n++) begin
            ra = pick(16);
            rb = pick(16);
            do_op(2, ra, rb, ref_mul(2, ra, rb), "rand_s16");
        end
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                do_op(3, 16'(i), 16'(j), ref_mul(3, 16'(i), 16'(j)), "exh_u4");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
